canvas_write_ctrl: RTL and testbench
====================================

// Module: canvas_write_ctrl
// PURPOSE
//  Sole writer of frame-buffer port A (wea/addra/dina) for the 1-bit 640x480 canvas.
//  - Shares that port between two requesters: brush-stamp paint requests from mouse input and a full-screen clear engine.
//  - Expands each paint request into a square brush of (2r+1)^2 pixel writes.
//  - Sequences a linear sweep of every visible pixel on clear.
// PARAMETERS
//  H_RES        640  visible width, pixels
//  V_RES        480  visible height, pixels
//  ADDR_W       19   frame-buffer address width; addr = {y[8:0], x[9:0]}
//  CLEAR_COLOR  1'b0 value written by the clear sweep
//  CLEAR_ON_RST 1    1: start a clear sweep automatically after reset
// PORTS
//  clk          in   1       pixel clock (25 MHz domain)
//  rst          in   1       synchronous, active-high reset
//  clear_req    in   1       request full-canvas clear (level or pulse, sampled each cycle)
//  paint_valid  in   1       paint request valid
//  paint_ready  out  1       request accepted when valid&&ready
//  paint_x      in   10      brush centre x (0..H_RES-1)
//  paint_y      in   10      brush centre y (0..V_RES-1)
//  paint_color  in   1       pixel value to write
//  brush_r      in   2       brush radius r (0..3); stamp = (2r+1)x(2r+1)
//  we           out  1       frame-buffer write enable (registered)
//  waddr        out  ADDR_W  frame-buffer write address (registered)
//  wdata        out  1       frame-buffer write data (registered)
//  busy         out  1       state != IDLE or clear pending
// BEHAVIOUR
//  - Clock and reset: clock clk; reset rst, synchronous, active-high.
//  - Reset values: we=0, waddr=0, wdata=0, clear_pend=0.
//    - State after reset: CLEAR if CLEAR_ON_RST, else IDLE.
//  - Handshake: paint_ready = (state==IDLE) && !clear_pend && !clear_req && !rst (combinational).
//    - A request is accepted only on valid&&ready.
//    - On accept, x, y, color and r are latched; inputs may change afterwards.
//  - FSM IDLE:
//    - clear_req or clear_pend -> CLEAR; x,y counters := 0; clear_pend := 0.
//    - else paint accept -> STAMP; dx := -r, dy := -r.
//  - FSM STAMP: one candidate pixel per cycle, dx fastest, dy slowest.
//    - px = x+dx, py = y+dy, 11-bit signed.
//    - In bounds (0<=px<H_RES, 0<=py<V_RES): issue we=1, waddr={py[8:0],px[9:0]}, wdata=color.
//    - Out of bounds: we=0 for that cycle; the cycle is still consumed.
//    - After (dx,dy)=(r,r) -> IDLE. A stamp takes exactly (2r+1)^2 cycles; r=0 takes 1 cycle.
//  - FSM CLEAR: writes CLEAR_COLOR at x 0..H_RES-1 (inner loop), y 0..V_RES-1.
//    - Takes H_RES*V_RES = 307200 cycles; the last write is at (639,479), then -> IDLE.
//  - Latency: a candidate issued in cycle n appears on we/waddr/wdata in cycle n+1.
//    - we is low in every cycle with no write; there are no gaps inside a sweep.
//  - Simultaneous events:
//    - clear_req and paint_valid in the same IDLE cycle: clear wins; the paint is not accepted (ready=0).
//    - clear_req during STAMP: sets clear_pend. The stamp finishes, then CLEAR starts; no paint is accepted in between.
//    - clear_req during CLEAR: ignored; the sweep is not restarted.
//  - Reset mid-operation: aborts any stamp or sweep immediately; we=0 in the next cycle; CLEAR_ON_RST applies.
//  - x/y counters wrap only via explicit compare to H_RES-1/V_RES-1; address never exceeds {479,639}.
// TESTING
//  - Reset with CLEAR_ON_RST=1:
//    - Expect 307200 consecutive we=1 with wdata=0.
//    - First waddr=0; waddr after 640 writes = {9'd1,10'd0}; last = {9'd479,10'd639}; then paint_ready=1.
//  - Paint x=100,y=50,r=1,color=1:
//    - 9 writes in 9 consecutive cycles.
//    - Addresses in order (99,49),(100,49),(101,49),(99,50) .. (101,51); wdata=1.
//  - Paint at corner x=0,y=0,r=2: 25 cycles, exactly 9 with we=1, covering (0..2,0..2); busy high 25 cycles.
//  - Paint x=639,y=479,r=0: single write at {9'd479,10'd639}; paint_ready back high the cycle after.
//  - clear_req pulsed in cycle 3 of an r=3 stamp:
//    - The stamp completes all 49 cycles, then the sweep starts with no idle cycle.
//    - paint_valid held high throughout is not accepted until the sweep ends.
//  - rst asserted mid-stamp (CLEAR_ON_RST=0): we=0 the next cycle; state IDLE; paint_ready=1 after rst drops.

Source files
------------

// File: rtl/canvas_write_ctrl.sv
// Sole writer of frame-buffer port A: arbitrates brush-stamp paint requests
// against a full-canvas clear sweep and emits one registered write per cycle.
module canvas_write_ctrl #(
  parameter int   H_RES        = 640,
  parameter int   V_RES        = 480,
  parameter int   ADDR_W       = 19,
  parameter logic CLEAR_COLOR  = 1'b0,
  parameter bit   CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              paint_valid,
  output logic              paint_ready,
  input  logic [9:0]        paint_x,
  input  logic [9:0]        paint_y,
  input  logic              paint_color,
  input  logic [1:0]        brush_r,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              wdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting; accepts paint requests, launches pending/requested clears
  // STAMP | one brush candidate per cycle, dx fastest, dy slowest
  // CLEAR | linear sweep of every visible pixel with CLEAR_COLOR
  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  localparam state_t              RST_STATE = CLEAR_ON_RST ? CLEAR : IDLE;
  localparam logic [9:0]          X_LAST    = 10'(H_RES - 1);
  localparam logic [9:0]          Y_LAST    = 10'(V_RES - 1);
  localparam logic signed [10:0]  PX_LIM    = 11'(H_RES);
  localparam logic signed [10:0]  PY_LIM    = 11'(V_RES);

  state_t             state, state_nxt;
  logic               clear_pend;
  logic [9:0]         cx, cy;
  logic signed [2:0]  dx, dy;
  logic [9:0]         lat_x, lat_y;
  logic               lat_color;
  logic [1:0]         lat_r;

  logic               accept, clear_go, stamp_last, clear_last;
  logic signed [2:0]  r_s, r_in;
  logic signed [10:0] px, py;
  logic               cand_we, cand_data;
  logic [ADDR_W-1:0]  cand_addr;

  assign paint_ready = (state == IDLE) && !clear_pend && !clear_req && !rst;
  assign accept      = paint_valid && paint_ready;
  assign clear_go    = clear_req || clear_pend;
  assign busy        = (state != IDLE) || clear_pend;

  assign r_s        = signed'({1'b0, lat_r});
  assign r_in       = signed'({1'b0, brush_r});
  assign stamp_last = (dx == r_s) && (dy == r_s);
  assign clear_last = (cx == X_LAST) && (cy == Y_LAST);

  assign px = signed'({1'b0, lat_x}) + signed'({{8{dx[2]}}, dx});
  assign py = signed'({1'b0, lat_y}) + signed'({{8{dy[2]}}, dy});

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_STATE;
      clear_pend <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      dx         <= '0;
      dy         <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_color  <= 1'b0;
      lat_r      <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= cand_we;
      waddr <= cand_addr;
      wdata <= cand_data;
      case (state)
        IDLE: begin
          if (clear_go) begin
            cx         <= '0;
            cy         <= '0;
            clear_pend <= 1'b0;
          end else if (accept) begin
            lat_x     <= paint_x;
            lat_y     <= paint_y;
            lat_color <= paint_color;
            lat_r     <= brush_r;
            dx        <= -r_in;
            dy        <= -r_in;
          end
        end
        STAMP: begin
          // A clear arriving on the final stamp cycle hands straight over to the sweep
          if (stamp_last) begin
            if (clear_go) begin
              cx         <= '0;
              cy         <= '0;
              clear_pend <= 1'b0;
            end
          end else begin
            if (clear_req) clear_pend <= 1'b1;
            if (dx == r_s) begin
              dx <= -r_s;
              dy <= dy + 3'sd1;
            end else begin
              dx <= dx + 3'sd1;
            end
          end
        end
        CLEAR: begin
          if (cx == X_LAST) begin
            cx <= '0;
            cy <= (cy == Y_LAST) ? '0 : cy + 10'd1;
          end else begin
            cx <= cx + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_go)    state_nxt = CLEAR;
        else if (accept) state_nxt = STAMP;
      end
      STAMP: begin
        if (stamp_last) state_nxt = clear_go ? CLEAR : IDLE;
      end
      CLEAR: begin
        if (clear_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cand_we   = 1'b0;
    cand_addr = '0;
    cand_data = 1'b0;
    case (state)
      STAMP: begin
        if (!px[10] && (px < PX_LIM) && !py[10] && (py < PY_LIM)) begin
          cand_we   = 1'b1;
          cand_addr = ADDR_W'({py[8:0], px[9:0]});
          cand_data = lat_color;
        end
      end
      CLEAR: begin
        cand_we   = 1'b1;
        cand_addr = ADDR_W'({cy[8:0], cx[9:0]});
        cand_data = CLEAR_COLOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_canvas_write_ctrl.sv
// Scoreboard bench for canvas_write_ctrl on a reduced 40x30 canvas so that
// full clear sweeps stay short; every write is checked in order by a monitor.
module tb_canvas_write_ctrl;
  localparam int H = 40;
  localparam int V = 30;

  logic        clk = 1'b0;
  logic        rst, clear_req, paint_valid, paint_ready, paint_color;
  logic [9:0]  paint_x, paint_y;
  logic [1:0]  brush_r;
  logic        we, wdata, busy;
  logic [18:0] waddr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] sb[$];

  canvas_write_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(19), .CLEAR_COLOR(1'b0),
                      .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .paint_valid(paint_valid),
    .paint_ready(paint_ready), .paint_x(paint_x), .paint_y(paint_y),
    .paint_color(paint_color), .brush_r(brush_r), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [19:0] pack(input int x, input int y, input logic c);
    logic [9:0] xv, yv;
    xv = x[9:0];
    yv = y[9:0];
    return {yv[8:0], xv, c};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_sweep();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) sb.push_back(pack(x, y, 1'b0));
  endtask

  // Expected brush writes, limited to the first 'lim' candidate cycles
  task automatic push_stamp(input int x, input int y, input int r, input logic c,
                            input int lim);
    int n = 0;
    for (int j = -r; j <= r; j++)
      for (int i = -r; i <= r; i++) begin
        if (n < lim && x + i >= 0 && x + i < H && y + j >= 0 && y + j < V)
          sb.push_back(pack(x + i, y + j, c));
        n++;
      end
  endtask

  task automatic paint(input int x, input int y, input int r, input logic c,
                       input bit hold);
    bit done = 0;
    paint_x = 10'(x); paint_y = 10'(y); brush_r = 2'(r); paint_color = c;
    paint_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = paint_ready;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL paint_accept_timeout: got ready=0, required ready=1");
    end
    if (!hold) paint_valid = 1'b0;
  endtask

  task automatic watch(input int clr_at, input int rst_at,
                       output int n_we, output int first, output int last,
                       output int n_busy, output int acc,
                       output logic rdy0, output logic rdy1, output logic we6);
    bit stop = 0;
    bit acc_now;
    logic b;
    n_we = 0; first = -1; last = -1; n_busy = 0; acc = -1;
    rdy0 = 1'bx; rdy1 = 1'bx; we6 = 1'bx;
    for (int i = 0; i < 3000 && !stop; i++) begin
      @(negedge clk);
      b = busy;
      acc_now = paint_valid && paint_ready;
      if (we) begin
        n_we++;
        if (first < 0) first = i;
        last = i;
      end
      if (b) n_busy++;
      if (acc_now && acc < 0) acc = i;
      if (i == 0) rdy0 = paint_ready;
      if (i == 1) rdy1 = paint_ready;
      if (i == 6) we6 = we;
      #1;
      stop = (sb.size() == 0) && !b;
      @(posedge clk); #1;
      if (acc_now) paint_valid = 1'b0;
      if (i == clr_at) clear_req = 1'b1;
      if (i == clr_at + 1) clear_req = 1'b0;
      if (i == rst_at) rst = 1'b1;
      if (i == rst_at + 1) rst = 1'b0;
    end
    if (!stop) begin
      n_cmp++; n_bad++;
      $display("FAIL watch_timeout: got %0d pending writes, required 0", sb.size());
    end
  endtask

  initial begin : monitor
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL wr_unexpected: got addr=%h data=%b, required no write", waddr, wdata);
        end else begin
          e = sb.pop_front();
          if ({waddr, wdata} !== e) begin
            n_bad++;
            $display("FAIL wr_seq: got addr=%h data=%b, required addr=%h data=%b",
                     waddr, wdata, e[19:1], e[0]);
          end
        end
      end
    end
  end

  initial begin : stim
    int n_we, first, last, n_busy, acc;
    logic rdy0, rdy1, we6;
    rst = 1'b1; clear_req = 1'b0; paint_valid = 1'b0;
    paint_x = '0; paint_y = '0; brush_r = '0; paint_color = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", int'(we), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_wdata", int'(wdata), 0);
    check("rst_ready", int'(paint_ready), 0);
    check("rst_busy", int'(busy), 1);
    @(posedge clk); #1;
    push_sweep();
    rst = 1'b0;

    // Power-on clear sweep
    watch(-10, -10, n_we, first, last, n_busy, acc, rdy0, rdy1, we6);
    check("boot_we_count", n_we, H * V);
    check("boot_first", first, 1);
    check("boot_last", last, H * V);
    check("boot_busy", n_busy, H * V);
    check("boot_ready_after", int'(paint_ready), 1);

    // 3x3 brush in open canvas
    push_stamp(10, 5, 1, 1'b1, 99);
    paint(10, 5, 1, 1'b1, 0);
    watch(-10, -10, n_we, first, last, n_busy, acc, rdy0, rdy1, we6);
    check("r1_we_count", n_we, 9);
    check("r1_first", first, 1);
    check("r1_last", last, 9);
    check("r1_busy", n_busy, 9);

    // 5x5 brush clipped at the top-left corner
    push_stamp(0, 0, 2, 1'b1, 99);
    paint(0, 0, 2, 1'b1, 0);
    watch(-10, -10, n_we, first, last, n_busy, acc, rdy0, rdy1, we6);
    check("corner_we_count", n_we, 9);
    check("corner_busy", n_busy, 25);
    check("corner_first", first, 13);
    check("corner_last", last, 25);

    // Single pixel at the bottom-right corner
    push_stamp(H - 1, V - 1, 0, 1'b1, 99);
    paint(H - 1, V - 1, 0, 1'b1, 0);
    watch(-10, -10, n_we, first, last, n_busy, acc, rdy0, rdy1, we6);
    check("r0_we_count", n_we, 1);
    check("r0_ready_during", int'(rdy0), 0);
    check("r0_ready_after", int'(rdy1), 1);

    // Clear pulsed mid-stamp with a paint request held throughout
    push_stamp(20, 15, 3, 1'b1, 99);
    push_sweep();
    sb.push_back(pack(5, 5, 1'b1));
    paint(20, 15, 3, 1'b1, 1);
    paint_x = 10'd5; paint_y = 10'd5; brush_r = 2'd0; paint_color = 1'b1;
    watch(1, -10, n_we, first, last, n_busy, acc, rdy0, rdy1, we6);
    check("pend_we_count", n_we, 49 + H * V + 1);
    check("pend_first", first, 1);
    check("pend_accept_cycle", acc, 49 + H * V);
    check("pend_last", last, 49 + H * V + 2);

    // Reset during a stamp aborts it and restarts the power-on sweep
    push_stamp(20, 15, 3, 1'b1, 5);
    push_sweep();
    paint(20, 15, 3, 1'b1, 0);
    watch(-10, 4, n_we, first, last, n_busy, acc, rdy0, rdy1, we6);
    check("rstmid_we_after", int'(we6), 0);
    check("rstmid_we_count", n_we, 5 + H * V);
    check("rstmid_first", first, 1);
    check("rstmid_last", last, 6 + H * V);
    check("rstmid_ready_after", int'(paint_ready), 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
